// File: rtl/icache_fetch_fifo_p.sv
// Instruction-cache fetch FIFO: circular buffer with wrap-bit pointers, zero-latency head peek,
// in-place status-field patching of occupied entries, and sticky overflow/underflow flags.
module icache_fetch_fifo_p #(
    parameter int WIDTH     = 38,
    parameter int DEPTH     = 8,
    localparam int PTRW     = $clog2(DEPTH),
    parameter int ST_LSB    = 2,
    parameter int ST_W      = 3,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             Wable,
    input  logic [WIDTH-1:0] Din,
    input  logic             Rable,
    output logic [WIDTH-1:0] FifoPreOut,
    output logic [PTRW-1:0]  FifoPrePtr,
    output logic             FifoValid,
    input  logic             StateWAble,
    input  logic [PTRW-1:0]  StatePtr,
    input  logic [ST_W-1:0]  StateDate,
    input  logic             FifoClean,
    output logic             FifoFull,
    output logic             FifoEmpty,
    output logic             FifoAlmostFull,
    output logic [PTRW:0]    FifoCount,
    output logic             FifoOvf,
    output logic             FifoUdf
);

    localparam logic [PTRW:0] AF_LVL = (PTRW+1)'(AF_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW:0]    wr_ptr;
    logic [PTRW:0]    rd_ptr;
    logic [PTRW:0]    count;
    logic [PTRW-1:0]  wr_idx;
    logic [PTRW-1:0]  rd_idx;
    logic [PTRW-1:0]  patch_off;
    logic             full;
    logic             empty;
    logic             push_acc;
    logic             pop_acc;
    logic             patch_hit;
    logic             patch_ok;
    logic             ovf;
    logic             udf;

    assign wr_idx = wr_ptr[PTRW-1:0];
    assign rd_idx = rd_ptr[PTRW-1:0];
    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTRW] != rd_ptr[PTRW]) && (wr_idx == rd_idx);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_acc = Wable && (!full || Rable);
    assign pop_acc  = Rable && !empty;

    // Occupied means the distance from head (mod DEPTH) is below the occupancy.
    assign patch_off = StatePtr - rd_idx;
    assign patch_hit = StateWAble && ({1'b0, patch_off} < count);
    assign patch_ok  = patch_hit && !(push_acc && (StatePtr == wr_idx));

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (FifoClean) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (Wable && full && !Rable) begin
                ovf <= 1'b1;
            end
            if (Rable && empty) begin
                udf <= 1'b1;
            end
        end
    end

    // Flush leaves entry contents alone; they are hidden by the empty-forces-zero peek.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!FifoClean) begin
            if (push_acc) begin
                mem[wr_idx] <= Din;
            end
            if (patch_ok) begin
                mem[StatePtr][ST_LSB +: ST_W] <= StateDate;
            end
        end
    end

    assign FifoPreOut     = empty ? '0 : mem[rd_idx];
    assign FifoPrePtr     = rd_idx;
    assign FifoValid      = !empty;
    assign FifoEmpty      = empty;
    assign FifoFull       = full;
    assign FifoCount      = count;
    assign FifoAlmostFull = (count >= AF_LVL);
    assign FifoOvf        = ovf;
    assign FifoUdf        = udf;

endmodule
